// File: rtl/proc_feeder_pkg.sv
// Shared constants for the program feeder: opcodes, FSM state encoding, defaults.
// Optional watchdog feature is selected with PROC_FEEDER_WATCHDOG_EN.
package proc_feeder_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int TMO_DEFAULT   = 15;

  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] MVI = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic is_mvi(input logic [2:0] op);
    return op == MVI;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program buffer: DEPTH x 9 words, synchronous write, asynchronous read.
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [8:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [8:0]    rdata_o
);

  logic [8:0] mem_q [DEPTH];

  always_ff @(posedge Clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_feeder.sv
// Feeds a stored program to a multicycle processor one instruction per Run pulse.
// Define PROC_FEEDER_WATCHDOG_EN to add a Done timeout that halts with Error.
module proc_feeder
  import proc_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int TMO   = TMO_DEFAULT
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   LoadEn,
  input  logic [8:0]             LoadData,
  input  logic                   LoadClr,
  input  logic                   Start,
  input  logic                   Done,
  output logic [8:0]             DIN,
  output logic                   Run,
  output logic [$clog2(DEPTH):0] PC,
  output logic                   Busy,
  output logic                   Halted,
  output logic                   Full,
  output logic                   Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  state_e        state_q, state_d;
  logic [LW-1:0] pc_q, pc_d;
  logic [LW-1:0] len_q, len_d;
  logic [2:0]    op_q, op_d;
  logic [LW-1:0] pc_done;
  logic [8:0]    word;
  logic          ram_we;
  logic          busy;
  logic          start_accept;
  logic          wd_expire;

  prog_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .Clock  (Clock),
    .we_i   (ram_we),
    .waddr_i(len_q[AW-1:0]),
    .wdata_i(LoadData),
    .raddr_i(pc_q[AW-1:0]),
    .rdata_o(word)
  );

  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign start_accept = Start && !busy;
  // An MVI consumes its immediate word too, so PC skips over it on completion.
  assign pc_done      = pc_q + LW'(is_mvi(op_q));

`ifdef PROC_FEEDER_WATCHDOG_EN
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  logic [CW-1:0] wd_q;
  logic          err_q;

  assign wd_expire = (state_q == ST_WAIT) && !Done && (wd_q == CW'(TMO - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != ST_WAIT) wd_q <= '0;
      else if (!wd_expire)    wd_q <= wd_q + 1'b1;
      if (start_accept)       err_q <= 1'b0;
      else if (wd_expire)     err_q <= 1'b1;
    end
  end

  assign Error = err_q;
`else
  localparam int unused_tmo = TMO;

  assign wd_expire = 1'b0;
  assign Error     = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      op_q    <= MV;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    op_d    = op_q;
    ram_we  = 1'b0;
    Run     = 1'b0;

    if (!busy) begin
      if (LoadClr) begin
        len_d = '0;
      end else if (LoadEn && (len_q != LEN_MAX)) begin
        ram_we = 1'b1;
        len_d  = len_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          pc_d    = '0;
          state_d = (len_q != '0) ? ST_ISSUE : ST_HALT;
        end
      end
      ST_ISSUE: begin
        Run     = 1'b1;
        op_d    = word[8:6];
        pc_d    = pc_q + 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (Done) begin
          pc_d    = pc_done;
          state_d = (pc_done < len_q) ? ST_ISSUE : ST_HALT;
        end else if (wd_expire) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign DIN    = (pc_q < len_q) ? word : 9'h000;
  assign PC     = pc_q;
  assign Busy   = busy;
  assign Halted = (state_q == ST_HALT);
  assign Full   = (len_q == LEN_MAX);

endmodule

// File: tb/tb_proc_feeder.sv
// Self-checking bench for proc_feeder: directed scenarios plus random programs
// checked against an instruction-level model of the feeder.
module tb_proc_feeder;

  localparam int DEPTH = 16;
  localparam int TMO   = 15;

  logic       Clock   = 1'b0;
  logic       Resetn  = 1'b0;
  logic       LoadEn  = 1'b0;
  logic [8:0] LoadData = '0;
  logic       LoadClr = 1'b0;
  logic       Start   = 1'b0;
  logic       Done    = 1'b0;
  logic [8:0] DIN;
  logic       Run, Busy, Halted, Full, Error;
  logic [4:0] PC;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] prog_m [DEPTH];
  int         len_m;

  always #5 Clock = ~Clock;

  proc_feeder #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .LoadEn  (LoadEn),
    .LoadData(LoadData),
    .LoadClr (LoadClr),
    .Start   (Start),
    .Done    (Done),
    .DIN     (DIN),
    .Run     (Run),
    .PC      (PC),
    .Busy    (Busy),
    .Halted  (Halted),
    .Full    (Full),
    .Error   (Error)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_run"},    32'(Run),    32'd0);
    chk({tag, "_din"},    32'(DIN),    32'd0);
    chk({tag, "_pc"},     32'(PC),     32'd0);
    chk({tag, "_busy"},   32'(Busy),   32'd0);
    chk({tag, "_halted"}, 32'(Halted), 32'd0);
    chk({tag, "_full"},   32'(Full),   32'd0);
    chk({tag, "_error"},  32'(Error),  32'd0);
  endtask

  task automatic load_prog(input int n);
    LoadClr = 1'b1;
    tick;
    LoadClr = 1'b0;
    for (int i = 0; i < n; i++) begin
      LoadEn   = 1'b1;
      LoadData = prog_m[i];
      tick;
    end
    LoadEn = 1'b0;
  endtask

  // Model: issue word at pc, show the following word (or 0) while waiting,
  // then advance by 2 for MVI and 1 otherwise until pc reaches the length.
  // A latency of 0 means pick 1..4 at random.
  task automatic run_prog(input int lat0, input int lat1, input bit noisy);
    int pc   = 0;
    int nrun = 0;
    int lat;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    while (pc < len_m) begin
      chk("issue_run",  32'(Run),  32'd1);
      chk("issue_din",  32'(DIN),  32'(prog_m[pc]));
      chk("issue_busy", 32'(Busy), 32'd1);
      if (noisy) Done = 1'($urandom_range(0, 1));
      tick;
      Done = 1'b0;
      nrun++;
      chk("wait_run", 32'(Run), 32'd0);
      chk("wait_din", 32'(DIN), (pc + 1 < len_m) ? 32'(prog_m[pc + 1]) : 32'd0);
      lat = (nrun == 1) ? lat0 : lat1;
      if (lat == 0) lat = $urandom_range(1, 4);
      for (int k = 1; k < lat; k++) begin
        if (noisy) begin
          Start    = 1'($urandom_range(0, 1));
          LoadEn   = 1'($urandom_range(0, 1));
          LoadClr  = 1'($urandom_range(0, 1));
          LoadData = 9'($urandom);
        end
        tick;
        chk("wait_run_hold", 32'(Run), 32'd0);
      end
      Start   = 1'b0;
      LoadEn  = 1'b0;
      LoadClr = 1'b0;
      Done    = 1'b1;
      tick;
      Done = 1'b0;
      pc += (prog_m[pc][8:6] == 3'b001) ? 2 : 1;
    end
    chk("end_run",    32'(Run),    32'd0);
    chk("end_halted", 32'(Halted), 32'd1);
    chk("end_busy",   32'(Busy),   32'd0);
    chk("end_pc",     32'(PC),     32'(pc));
    $display("run: len=%0d instructions=%0d final_pc=%0d", len_m, nrun, pc);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    chk_idle_outputs("reset");
    Resetn = 1'b1;
    tick;
    chk_idle_outputs("post_reset");

    // Done outside WAIT is ignored
    Done = 1'b1;
    tick;
    Done = 1'b0;
    chk("idle_done_busy", 32'(Busy), 32'd0);
    chk("idle_done_pc",   32'(PC),   32'd0);

    // Empty buffer: Start goes straight to HALT
    len_m = 0;
    run_prog(1, 1, 1'b0);
    tick;
    chk("empty_no_run", 32'(Run), 32'd0);

    // MVI R0,#5
    prog_m[0] = 9'o100;
    prog_m[1] = 9'h005;
    len_m = 2;
    load_prog(len_m);
    run_prog(1, 1, 1'b0);

    // MV R1,R0 ; ADD R0,R1 with Done at 1 and 3 cycles
    prog_m[0] = 9'o010;
    prog_m[1] = 9'o201;
    len_m = 2;
    load_prog(len_m);
    run_prog(1, 3, 1'b0);

    // MVI as the last word: immediate reads as 0
    prog_m[0] = 9'o210;
    prog_m[1] = 9'o170;
    len_m = 2;
    load_prog(len_m);
    run_prog(2, 2, 1'b0);

    // Fill to DEPTH, 17th word ignored, then clear
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 9'($urandom);
    LoadClr = 1'b1;
    tick;
    LoadClr = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      LoadEn   = 1'b1;
      LoadData = (i < DEPTH) ? prog_m[i] : 9'($urandom);
      tick;
      chk("fill_full", 32'(Full), (i >= DEPTH - 1) ? 32'd1 : 32'd0);
    end
    LoadEn = 1'b0;
    len_m = DEPTH;
    run_prog(0, 0, 1'b1);
    LoadClr = 1'b1;
    tick;
    LoadClr = 1'b0;
    chk("clr_full", 32'(Full), 32'd0);
    len_m = 0;
    run_prog(1, 1, 1'b0);

    // Random programs with noise on ignored inputs
    for (int r = 0; r < 8; r++) begin
      len_m = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) prog_m[i] = 9'($urandom);
      load_prog(len_m);
      run_prog(0, 0, 1'b1);
    end

    // Start in WAIT is ignored, then reset mid-instruction
    prog_m[0] = 9'o312;
    len_m = 1;
    load_prog(len_m);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    chk("wait_busy", 32'(Busy), 32'd1);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    chk("wait_start_run",  32'(Run),  32'd0);
    chk("wait_start_pc",   32'(PC),   32'd1);
    chk("wait_start_busy", 32'(Busy), 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    tick;
    Resetn = 1'b1;
    tick;
    len_m = 0;
    run_prog(1, 1, 1'b0);

    // Done withheld
    prog_m[0] = 9'o312;
    len_m = 1;
    load_prog(len_m);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
`ifdef PROC_FEEDER_WATCHDOG_EN
    for (int k = 0; k < TMO - 1; k++) tick;
    chk("wd_pre_busy",  32'(Busy),  32'd1);
    chk("wd_pre_error", 32'(Error), 32'd0);
    tick;
    chk("wd_halted", 32'(Halted), 32'd1);
    chk("wd_error",  32'(Error),  32'd1);
    chk("wd_pc",     32'(PC),     32'd1);
    run_prog(1, 1, 1'b0);
    chk("wd_error_clr", 32'(Error), 32'd0);
`else
    for (int k = 0; k < 40; k++) tick;
    chk("nowd_busy",  32'(Busy),  32'd1);
    chk("nowd_error", 32'(Error), 32'd0);
    Done = 1'b1;
    tick;
    Done = 1'b0;
    chk("nowd_halted", 32'(Halted), 32'd1);
    chk("nowd_pc",     32'(PC),     32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_feeder.md
PROC_FEEDER -- requirements
Module: proc_feeder

Interface
REQ-001 Parameter DEPTH, default 16, program buffer depth in 9-bit words (power of 2).
REQ-002 Parameter TMO, default 15, cycles allowed to wait for Done (used only with the watchdog feature).
REQ-003 Clock  input  1  system clock; all state changes on rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 LoadEn  input  1  write LoadData into the buffer at the next free word.
REQ-006 LoadData  input  9  program word (opcode [8:6], Rx [5:3], Ry [2:0], or MVI immediate).
REQ-007 LoadClr  input  1  empty the program buffer (length := 0).
REQ-008 Start  input  1  begin execution from word 0.
REQ-009 Done  input  1  processor instruction-complete strobe.
REQ-010 DIN  output  9  instruction or immediate word to the processor.
REQ-011 Run  output  1  instruction-valid strobe to the processor.
REQ-012 PC  output  log2(DEPTH)+1  index of the word currently addressed.
REQ-013 Busy, Halted, Full, Error  output  1 each  status flags.

Function
REQ-014 States: IDLE, ISSUE, WAIT, HALT; Busy = 1 in ISSUE or WAIT.
REQ-015 Load (not Busy): LoadEn with length < DEPTH writes buffer[length] and increments length; at length = DEPTH, LoadEn is ignored and Full = 1.
REQ-016 LoadClr (not Busy) sets length := 0 and Full := 0; LoadClr wins over a simultaneous LoadEn.
REQ-017 LoadEn and LoadClr are ignored while Busy.
REQ-018 IDLE/HALT + Start: PC := 0; next state is ISSUE if length > 0, else HALT.
REQ-019 Start while Busy is ignored.
REQ-020 ISSUE (exactly 1 cycle): Run = 1, DIN = buffer[PC]; latch opcode; PC := PC+1; go to WAIT.
REQ-021 WAIT: Run = 0, DIN = buffer[PC] combinationally, so an MVI immediate is presented in the processor's T1.
REQ-022 DIN = 9'h000 whenever PC >= length.
REQ-023 WAIT + Done: if the latched opcode = MVI (2'b01 in [7:6] of a 3-bit opcode 3'b001), PC := PC+1 additionally.
REQ-024 WAIT + Done, after the PC update: go to ISSUE if the new PC < length, else HALT.
REQ-025 Run is never asserted in consecutive cycles; exactly one Run pulse per instruction.
REQ-026 MVI as the last word (immediate missing): DIN = 0 in WAIT, completes normally, then HALT.
REQ-027 HALT: Halted = 1, Run = 0, PC holds its value.
REQ-028 Done outside WAIT is ignored.

Reset
REQ-029 On Resetn = 0, at any time including mid-instruction:
  - state := IDLE; PC := 0; length := 0.
  - Run = 0, DIN = 0, Busy = Halted = Full = Error = 0.
  - Buffer contents are not required to reset.

Configuration
REQ-030 Macro PROC_FEEDER_WATCHDOG_EN is defined:
  - a counter clears on entering WAIT.
  - If Done is not seen within TMO cycles in WAIT, Error := 1 and state := HALT.
  - Error clears on Start or reset.
REQ-031 Macro PROC_FEEDER_WATCHDOG_EN is undefined: no counter is built, Error is tied to 0, and WAIT waits indefinitely.

Structure
REQ-032 Package proc_feeder_pkg holds:
  - opcode constants MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
  - the state encoding;
  - the DEPTH default.
REQ-033 Sub-module prog_ram (DEPTH x 9, synchronous write, asynchronous read) holds the buffer; the FSM, PC and length logic live in proc_feeder.

Verification
REQ-034 Load MVI R0,#5 (9'o100, 9'h005), then Start -> one Run pulse with DIN = 9'o100; DIN = 9'h005 next cycle; after Done: PC = 2, Halted = 1.
REQ-035 Load MV R1,R0 then ADD R0,R1; Start with a model asserting Done 1 and 3 cycles after Run -> two Run pulses carrying 9'o010 and 9'o201; Halted with PC = 2.
REQ-036 Load 17 words with DEPTH = 16 -> Full = 1 after the 16th word; the 17th is ignored; LoadClr then gives Full = 0 and length 0.
REQ-037 Start with an empty buffer -> HALT next cycle and Run never asserted; Start in WAIT -> no effect.
REQ-038 Resetn low while in WAIT -> IDLE immediately with Run = 0, PC = 0, Busy = 0.
REQ-039 With PROC_FEEDER_WATCHDOG_EN defined and Done withheld -> Error = 1 and Halted = 1 after 15 WAIT cycles.
